// File: rtl/pack_stream_arbiter.sv
// Round-robin, packet-locked arbiter sharing one N-byte AXI-Stream packing datapath
// between M sources; the granted index travels with every beat on out_tid.
module pack_stream_arbiter #(
  parameter int N   = 10,
  parameter int M   = 4,
  parameter int IDW = (M > 1) ? $clog2(M) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [M-1:0]     src_en,
  input  logic [8*N*M-1:0] in_tdata,
  input  logic [N*M-1:0]   in_tkeep,
  input  logic [M-1:0]     in_tlast,
  input  logic [M-1:0]     in_tvalid,
  output logic [M-1:0]     in_tready,
  output logic [8*N-1:0]   out_tdata,
  output logic [N-1:0]     out_tkeep,
  output logic             out_tlast,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [IDW-1:0]   out_tid,
  output logic             busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_rr_ptr;

  logic [M-1:0]     w_req;
  logic [IDW-1:0]   w_pick;
  logic [8*N-1:0]   w_sel_tdata;
  logic [N-1:0]     w_sel_tkeep;
  logic             w_sel_tlast;
  logic             w_sel_tvalid;
  logic             w_last_xfer;
  logic [IDW-1:0]   w_next_ptr;

  // First requester at or above ptr wins; otherwise the lowest requester (wrap-around).
  function automatic logic [IDW-1:0] rr_pick(input logic [M-1:0] req,
                                             input logic [IDW-1:0] ptr);
    logic [IDW-1:0] pick;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (!found && req[i] && (IDW'(i) >= ptr)) begin
        found = 1'b1;
        pick  = IDW'(i);
      end
    end
    for (int i = 0; i < M; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        pick  = IDW'(i);
      end
    end
    return pick;
  endfunction

  assign w_req  = in_tvalid & src_en;
  assign w_pick = rr_pick(w_req, r_rr_ptr);

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tkeep  = '0;
    w_sel_tlast  = 1'b0;
    w_sel_tvalid = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_tdata  = in_tdata[8*N*i +: 8*N];
        w_sel_tkeep  = in_tkeep[N*i +: N];
        w_sel_tlast  = in_tlast[i];
        w_sel_tvalid = in_tvalid[i];
      end
    end
  end

  always_comb begin
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tvalid = 1'b0;
    out_tid    = '0;
    in_tready  = '0;
    if (r_state == S_LOCKED) begin
      out_tdata  = w_sel_tdata;
      out_tkeep  = w_sel_tkeep;
      out_tlast  = w_sel_tlast;
      out_tvalid = w_sel_tvalid;
      out_tid    = r_grant;
      for (int i = 0; i < M; i++) begin
        in_tready[i] = (r_grant == IDW'(i)) ? out_tready : 1'b0;
      end
    end
  end

  assign w_last_xfer = (r_state == S_LOCKED) && w_sel_tvalid && out_tready && w_sel_tlast;
  assign w_next_ptr  = (r_grant == IDW'(M - 1)) ? '0 : r_grant + 1'b1;
  assign busy        = (r_state == S_LOCKED);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Grant is held through valid gaps and src_en changes until tlast is accepted.
          if (w_last_xfer) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_stream_arbiter.sv
// Directed bench for pack_stream_arbiter (M=2, N=10): reset, contention, valid gaps,
// backpressure, fairness, enable masking and mid-packet reset abort.
module tb_pack_stream_arbiter;

  localparam int N   = 10;
  localparam int M   = 2;
  localparam int IDW = 1;
  localparam int BW  = 3 + IDW + M + N + 8*N;

  localparam logic [79:0] D_A  = "ABCDEFGHIJ";
  localparam logic [79:0] D_K  = "KLMONPQRST";
  localparam logic [79:0] D_U  = "UVWXYabcde";
  localparam logic [79:0] D_F  = "fghijklmno";
  localparam logic [79:0] D_P  = "pqrstuvwxy";
  localparam logic [9:0]  K_A  = 10'b0001101011;
  localparam logic [9:0]  K_K  = 10'b1001001111;
  localparam logic [9:0]  K_U  = 10'b1011110000;
  localparam logic [9:0]  K_F  = 10'b1010101000;
  localparam logic [9:0]  K_Z  = 10'b0000000000;

  logic             aclk;
  logic             aresetn;
  logic [M-1:0]     src_en;
  logic [8*N*M-1:0] in_tdata;
  logic [N*M-1:0]   in_tkeep;
  logic [M-1:0]     in_tlast;
  logic [M-1:0]     in_tvalid;
  logic [M-1:0]     in_tready;
  logic [8*N-1:0]   out_tdata;
  logic [N-1:0]     out_tkeep;
  logic             out_tlast;
  logic             out_tvalid;
  logic             out_tready;
  logic [IDW-1:0]   out_tid;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] e;

  pack_stream_arbiter #(.N(N), .M(M)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .src_en     (src_en),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tid    (out_tid),
    .busy       (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [BW-1:0] out_bus();
    return {busy, out_tvalid, out_tlast, out_tid, in_tready, out_tkeep, out_tdata};
  endfunction

  function automatic logic [BW-1:0] exp_bus(input logic b, input logic v, input logic l,
                                            input logic [IDW-1:0] tid, input logic [M-1:0] rdy,
                                            input logic [9:0] k, input logic [79:0] d);
    return {b, v, l, tid, rdy, k, d};
  endfunction

  task automatic set_src(input int i, input logic v, input logic [79:0] d,
                         input logic [9:0] k, input logic l);
    in_tvalid[i]        = v;
    in_tdata[80*i +: 80] = d;
    in_tkeep[10*i +: 10] = k;
    in_tlast[i]         = l;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn    = 1'b0;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    src_en     = 2'b11;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn    = 1'b0;
    src_en     = 2'b11;
    out_tready = 1'b1;
    set_src(0, 1'b1, D_A, K_A, 1'b1);
    set_src(1, 1'b1, D_U, K_U, 1'b1);
    @(negedge aclk);
    @(negedge aclk);
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL reset_hold got %h exp %h", out_bus(), e); end
    aresetn = 1'b1;
    #1;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL reset_release_idle got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, K_A, D_A);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL reset_first_grant got %h exp %h", out_bus(), e); end
  endtask

  task automatic test_contention();
    apply_reset();
    set_src(0, 1'b1, D_A, K_A, 1'b0);
    set_src(1, 1'b1, D_U, K_U, 1'b1);
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL cont_arb_cycle got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, K_A, D_A);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL cont_src0_beat1 got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    set_src(0, 1'b1, D_K, K_K, 1'b1);
    #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, K_K, D_K);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL cont_src0_beat2 got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    set_src(0, 1'b0, D_K, K_K, 1'b1);
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL cont_bubble got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, K_U, D_U);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL cont_src1_beat got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    set_src(1, 1'b0, D_U, K_U, 1'b1);
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL cont_end_idle got %h exp %h", out_bus(), e); end
  endtask

  task automatic test_valid_gaps();
    apply_reset();
    set_src(0, 1'b1, D_A, K_A, 1'b0);
    set_src(1, 1'b1, D_U, K_U, 1'b1);
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, K_A, D_A);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL gap_beat1 got %h exp %h", out_bus(), e); end
    for (int g = 0; g < 2; g++) begin
      @(negedge aclk);
      set_src(0, 1'b0, D_A, K_A, 1'b0);
      #1;
      e = exp_bus(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, K_A, D_A);
      checks++;
      if (out_bus() !== e) begin errors++; $display("FAIL gap_hold%0d got %h exp %h", g, out_bus(), e); end
    end
    @(negedge aclk);
    set_src(0, 1'b1, D_K, K_Z, 1'b1);
    #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, K_Z, D_K);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL gap_last_keep0 got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    set_src(0, 1'b0, D_K, K_Z, 1'b1);
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL gap_bubble got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, K_U, D_U);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL gap_src1_after got %h exp %h", out_bus(), e); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_tready = 1'b0;
    set_src(1, 1'b1, D_F, K_F, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk); #1;
      e = exp_bus(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, K_F, D_F);
      checks++;
      if (out_bus() !== e) begin errors++; $display("FAIL bp_stall%0d got %h exp %h", c, out_bus(), e); end
    end
    @(negedge aclk);
    out_tready = 1'b1;
    #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, K_F, D_F);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL bp_release got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    set_src(1, 1'b0, D_F, K_F, 1'b1);
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL bp_done_idle got %h exp %h", out_bus(), e); end
  endtask

  task automatic test_fairness();
    int cnt0;
    int cnt1;
    logic tid;
    cnt0 = 0;
    cnt1 = 0;
    apply_reset();
    set_src(0, 1'b1, D_A, K_A, 1'b1);
    set_src(1, 1'b1, D_P, K_U, 1'b1);
    for (int c = 0; c < 20; c++) begin
      #1;
      tid = ((c / 2) % 2) == 1;
      if ((c % 2) == 0) e = '0;
      else if (!tid)    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, K_A, D_A);
      else              e = exp_bus(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, K_U, D_P);
      checks++;
      if (out_bus() !== e) begin errors++; $display("FAIL fair_cycle%0d got %h exp %h", c, out_bus(), e); end
      if (out_tvalid && out_tready) begin
        if (out_tid == 1'b0) cnt0++;
        else                 cnt1++;
      end
      @(negedge aclk);
    end
    in_tvalid = '0;
    checks++;
    if (cnt0 !== 5) begin errors++; $display("FAIL fair_count_src0 got %0d exp 5", cnt0); end
    checks++;
    if (cnt1 !== 5) begin errors++; $display("FAIL fair_count_src1 got %0d exp 5", cnt1); end
  endtask

  task automatic test_enable_abort();
    apply_reset();
    src_en = 2'b10;
    set_src(0, 1'b1, D_A, K_A, 1'b1);
    set_src(1, 1'b1, D_U, K_U, 1'b0);
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, K_U, D_U);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL en_mask_grant got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    src_en = 2'b00;
    set_src(1, 1'b1, D_F, K_F, 1'b0);
    #1;
    e = exp_bus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, K_F, D_F);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL en_clear_keeps_grant got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    aresetn = 1'b0;
    #1;
    e = '0;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL abort_same_cycle got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL abort_held got %h exp %h", out_bus(), e); end
    aresetn = 1'b1;
    src_en  = 2'b11;
    #1;
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL abort_release_idle got %h exp %h", out_bus(), e); end
    @(negedge aclk); #1;
    e = exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, K_A, D_A);
    checks++;
    if (out_bus() !== e) begin errors++; $display("FAIL abort_restart_ptr0 got %h exp %h", out_bus(), e); end
    @(negedge aclk);
    in_tvalid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    test_reset();
    test_contention();
    test_valid_gaps();
    test_backpressure();
    test_fairness();
    test_enable_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pack_stream_arbiter.md
Name: pack_stream_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one byte-packing datapath (N-byte AXI-Stream with tkeep) between M requesting streams.
- Sits directly upstream of the packer: selects one source, holds the grant until that source's tlast beat is accepted, then re-arbitrates.
- Also carries the granted source index with every beat so the downstream sink can demultiplex the packed output.

Parameters:
- N, 10, bytes per beat. tdata is 8*N bits; tkeep is N bits.
- M, 4, number of requesters (2..16).
- IDW, $clog2(M) with a minimum of 1, width of out_tid.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- src_en  in  M  per-source enable (configuration). A source with its bit clear is never granted.
- in_tdata  in  8*N*M  source i occupies bits [8*N*i +: 8*N]
- in_tkeep  in  N*M  source i occupies bits [N*i +: N]
- in_tlast  in  M  last beat of packet, per source
- in_tvalid  in  M  per-source valid
- in_tready  out  M  per-source ready
- out_tdata  out  8*N  to packer
- out_tkeep  out  N  to packer
- out_tlast  out  1  to packer
- out_tvalid  out  1  to packer
- out_tready  in  1  from packer
- out_tid  out  IDW  index of the granted source
- busy  out  1  high while in LOCKED

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on aresetn, clocked by aclk.
- While aresetn=0:
  - state=IDLE, grant=0, rr_ptr=0.
  - out_tvalid=0, out_tlast=0, out_tdata=0, out_tkeep=0, out_tid=0.
  - in_tready=0, busy=0.
- Reset asserted mid-packet aborts the packet. No beat is accepted in or after the reset cycle.
- FSM states:
  - IDLE:
    - in_tready=0, out_tvalid=0, outputs zeroed.
    - req = in_tvalid & src_en. If req≠0, choose the first set bit of req scanning upward from rr_ptr, wrapping modulo M.
    - On the clock edge: grant <= chosen index, go to LOCKED.
    - Arbitration latency: 1 cycle from valid to first possible transfer.
  - LOCKED:
    - Combinational pass-through: out_tdata/tkeep/tlast/tvalid = source[grant] fields; out_tid=grant.
    - in_tready[grant]=out_tready. All other in_tready bits = 0.
    - Beat transfers when out_tvalid & out_tready.
    - On a transfer with out_tlast=1: rr_ptr <= (grant+1) mod M, go to IDLE.
    - This gives exactly one idle bubble cycle between packets.
- No beat is lost, duplicated or reordered.
- tdata/tkeep pass unmodified, including tkeep=0 beats.
- Grant is held regardless of valid gaps in the granted source. Other sources wait.
- src_en is sampled only in IDLE. Clearing a source's bit while it holds the grant does not abort its packet.
- Source holding its tvalid with no tlast keeps the grant indefinitely. No timeout.
- All M sources requesting every cycle: grants cycle 0,1,…,M-1,0… Each source gets exactly one packet per round.
- Single requester: re-granted after each packet, with the 1-cycle bubble.
- out_tready=0 while LOCKED: outputs remain stable and no state change.

Test Plan (M=2, N=10):
- Reset: hold aresetn=0 with in_tvalid=2'b11 -> in_tready=0, out_tvalid=0, busy=0. After release, first grant goes to source 0 (out_tid=0).
- Contention, back-to-back: src0 sends "ABCDEFGHIJ"/keep 10'b0001101011 then "KLMONPQRST"/10'b1001001111 with tlast. src1 simultaneously sends "UVWXYabcde"/10'b1011110000 with tlast.
  -> Output order: src0 beat 1, src0 beat 2 (tid=0), one bubble, src1 beat (tid=1). in_tready[1]=0 throughout src0's packet.
- Valid gaps in granted source: src0 drops tvalid for 2 cycles mid-packet while src1 is valid -> src1 not granted until src0's tlast transfers.
- Backpressure: out_tready=0 for 3 cycles on src1 beat "fghijklmno"/10'b1010101000 -> out_tdata/out_tkeep/out_tid stable and in_tready[1]=0 for those cycles. Transfer occurs on the first ready cycle.
- Fairness: both sources send continuous 1-beat packets for 20 cycles -> out_tid alternates 0,1,0,1…. Each source gets 5 packets, one bubble between each.
- Enable and reset abort: src_en=2'b10 with both valid -> only source 1 granted. Then assert aresetn=0 mid-packet -> outputs zero in the same cycle, and after release arbitration restarts from rr_ptr=0.
